// File: rtl/phot_pkg.sv
// Shared constants, counter type and saturating increment for the photon gate/histogrammer.
// The IPI histogram is compiled in only when PHOT_IPI_HIST_EN is defined.
package phot_pkg;

  localparam int NCH_MAX  = 32;
  localparam int NIPI_MAX = 256;
  localparam int CW_MAX   = 32;

  typedef logic [CW_MAX-1:0] cnt_t;

  localparam logic RD_SEL_CNT = 1'b0;
  localparam logic RD_SEL_IPI = 1'b1;

  typedef enum logic {
    SW_IDLE  = 1'b0,
    SW_SWEEP = 1'b1
  } sweep_state_e;

  // Adds inc to v, sticking at the all-ones value of a w-bit counter.
  function automatic cnt_t sat_inc(input cnt_t v, input logic inc, input int unsigned w);
    cnt_t top_val;
    top_val = (w >= CW_MAX) ? '1 : ((cnt_t'(1) << w) - cnt_t'(1));
    return (inc && (v != top_val)) ? v + cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/ipi_hist.sv
// Inter-photon-interval histogram: NIPI saturating bins, one-bin-per-cycle clear sweep,
// combinational read of the current (pre-increment) bin value.
module ipi_hist
  import phot_pkg::*;
#(
  parameter int CW   = 32,
  parameter int NIPI = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_start,
  input  logic                    inc_en,
  input  logic [$clog2(NIPI)-1:0] inc_idx,
  input  logic [7:0]              rd_addr,
  output logic [CW-1:0]           rd_val,
  output sweep_state_e            state_o
);

  localparam int AW = $clog2(NIPI);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] bins_q [NIPI];
  logic [CW-1:0] bins_d [NIPI];
  logic          sweep_clr;
  logic          inc_ok;
  cnt_t          inc_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SW_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A start while sweeping rewinds the pointer, so the sweep always ends NIPI cycles after the last start.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr_start) begin
      state_d = SW_SWEEP;
      ptr_d   = '0;
    end else if (state_q == SW_SWEEP) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(NIPI - 1)) begin
        state_d = SW_IDLE;
      end
    end
  end

  always_comb begin
    sweep_clr = (state_q == SW_SWEEP);
    inc_ok    = (state_q == SW_IDLE) && !clr_start && inc_en;
    state_o   = state_q;
  end

  assign inc_val = sat_inc(cnt_t'(bins_q[inc_idx]), 1'b1, CW);

  always_comb begin
    bins_d = bins_q;
    if (sweep_clr) begin
      bins_d[ptr_q] = '0;
    end else if (inc_ok) begin
      bins_d[inc_idx] = inc_val[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NIPI; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      bins_q <= bins_d;
    end
  end

  assign rd_val = ({1'b0, rd_addr} < 9'(NIPI)) ? bins_q[rd_addr[AW-1:0]] : '0;

endmodule

// File: rtl/phot_gate_histo.sv
// Multi-channel photon gate: edge detect, veto window, masked coincidence outputs,
// per-channel saturating counters; IPI histogram only when PHOT_IPI_HIST_EN is defined.
module phot_gate_histo
  import phot_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int CW   = 32,
  parameter int NIPI = 64,
  parameter int VW   = 8
) (
  input  logic           clkin,
  input  logic           nrst,
  input  logic           passthrough,
  input  logic           edge_only,
  input  logic [NCH-1:0] lvds_rx,
  input  logic [NCH-1:0] mask1,
  input  logic [NCH-1:0] mask2,
  input  logic [VW-1:0]  cycles_to_veto,
  input  logic           clr_req,
  output logic           clr_busy,
  input  logic           rd_sel,
  input  logic [7:0]     rd_addr,
  output logic [CW-1:0]  rd_data,
  output logic           out1,
  output logic           out2,
  output logic           anyphot,
  output logic           inveto,
  output logic           collision
);

  localparam int CH_AW = $clog2(NCH);

  logic [NCH-1:0] lvds_q, lvds_d;
  logic [VW-1:0]  ivc_q, ivc_d;
  logic [2:0]     clr_sync_q, clr_sync_d;
  logic           out1_q, out1_d;
  logic           out2_q, out2_d;
  logic           anyphot_q, anyphot_d;
  logic           inveto_q, inveto_d;
  logic           collision_q, collision_d;
  logic [CW-1:0]  rd_data_q, rd_data_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  cnt_t           cnt_sum [NCH];

  logic [NCH-1:0] raw;
  logic [NCH-1:0] phot;
  logic           veto_now;
  logic           accept;
  logic           clr_start;
  logic           busy;
  logic [CW-1:0]  ipi_rd;

  // Front end: edge detect and veto gating.
  always_comb begin
    raw      = edge_only ? (lvds_rx & ~lvds_q) : lvds_rx;
    veto_now = (ivc_q < cycles_to_veto);
    phot     = (passthrough || veto_now) ? '0 : raw;
    accept   = |phot;
    lvds_d   = lvds_rx;
  end

  // Interval counter: cleared by an accepted photon, saturates, holds in passthrough.
  always_comb begin
    ivc_d = ivc_q;
    if (!passthrough) begin
      if (accept) begin
        ivc_d = '0;
      end else if (ivc_q != '1) begin
        ivc_d = ivc_q + 1'b1;
      end
    end
  end

  always_comb begin
    out1_d      = passthrough ? (|lvds_rx) : (|(phot & mask1));
    out2_d      = passthrough ? (|(lvds_rx & mask2)) : (|(phot & mask2));
    anyphot_d   = accept;
    collision_d = !passthrough && veto_now && (|raw);
    inveto_d    = (ivc_d < cycles_to_veto);
  end

  // Two flops resynchronise the asynchronous clear level; the third gives its rising edge.
  always_comb begin
    clr_sync_d = {clr_sync_q[1:0], clr_req};
    clr_start  = clr_sync_q[1] & ~clr_sync_q[2];
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_sum[i] = sat_inc(cnt_t'(cnt_q[i]), phot[i], CW);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (clr_start) begin
        cnt_d[i] = '0;
      end else if (!busy) begin
        cnt_d[i] = cnt_sum[i][CW-1:0];
      end
    end
  end

`ifdef PHOT_IPI_HIST_EN
  localparam int IPI_AW = $clog2(NIPI);

  sweep_state_e      sweep_state;
  logic              ipi_inc;
  logic [IPI_AW-1:0] ipi_idx;

  assign ipi_inc = accept && (int'(ivc_q) < NIPI);
  assign ipi_idx = IPI_AW'(ivc_q);

  ipi_hist #(
    .CW   (CW),
    .NIPI (NIPI)
  ) u_ipi_hist (
    .clk       (clkin),
    .rst_n     (nrst),
    .clr_start (clr_start),
    .inc_en    (ipi_inc),
    .inc_idx   (ipi_idx),
    .rd_addr   (rd_addr),
    .rd_val    (ipi_rd),
    .state_o   (sweep_state)
  );

  assign busy = (sweep_state == SW_SWEEP);
`else
  // Without storage the clear degenerates to a single-cycle busy pulse.
  logic busy_q, busy_d;

  assign busy_d = clr_start;

  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign ipi_rd = '0;
`endif

  always_comb begin
    rd_data_d = '0;
    if (rd_sel == RD_SEL_CNT) begin
      if (rd_addr < 8'(NCH)) begin
        rd_data_d = cnt_q[CH_AW'(rd_addr)];
      end
    end else begin
      rd_data_d = ipi_rd;
    end
  end

  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      lvds_q      <= '0;
      ivc_q       <= '1;
      clr_sync_q  <= '0;
      out1_q      <= 1'b0;
      out2_q      <= 1'b0;
      anyphot_q   <= 1'b0;
      inveto_q    <= 1'b0;
      collision_q <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lvds_q      <= lvds_d;
      ivc_q       <= ivc_d;
      clr_sync_q  <= clr_sync_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      anyphot_q   <= anyphot_d;
      inveto_q    <= inveto_d;
      collision_q <= collision_d;
      rd_data_q   <= rd_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out1      = out1_q;
  assign out2      = out2_q;
  assign anyphot   = anyphot_q;
  assign inveto    = inveto_q;
  assign collision = collision_q;
  assign rd_data   = rd_data_q;
  assign clr_busy  = busy;

endmodule

// File: doc/phot_gate_histo.md
# phot_gate_histo

Parametrised successor to the single-channel photon gate/histogrammer. Sits on `clkin` behind the LVDS receivers. It takes `NCH` photon lines, does optional edge detection and a programmable veto window, and drives two masked coincidence outputs. It also keeps per-channel saturating hit counters and an `NIPI`-bin inter-photon-interval histogram, all read through an address/data port instead of wide array outputs.

## Interface
- `NCH`, 8: number of photon input channels (2..32).
- `CW`, 32: width of each histogram/counter word.
- `NIPI`, 64: IPI histogram bins (power of two, 16..256).
- `VW`, 8: width of the veto/interval cycle counter.

- `clkin`  in  1: sole clock.
- `nrst`  in  1: asynchronous active-low reset.
- `passthrough`  in  1: bypass mode.
- `edge_only`  in  1: count only rising edges per channel.
- `lvds_rx`  in  NCH: photon lines, synchronous to `clkin`.
- `mask1`, `mask2`  in  NCH: channel masks for `out1`/`out2`.
- `cycles_to_veto`  in  VW: veto window length in cycles after an accepted photon.
- `clr_req`  in  1: asynchronous histogram-clear request, level.
- `clr_busy`  out  1: clear sweep in progress.
- `rd_sel`  in  1: 0 = channel counters, 1 = IPI histogram.
- `rd_addr`  in  8: bin or channel index.
- `rd_data`  out  CW: read data.
- `out1`, `out2`  out  1: masked accepted-photon outputs.
- `anyphot`  out  1: any accepted photon.
- `inveto`  out  1: veto window active.
- `collision`  out  1: a photon arrived while in veto.

## Operation
- Edge detect: when `edge_only` is set, `raw = lvds_rx & ~lvds_q`, where `lvds_q` is `lvds_rx` registered. Otherwise `raw = lvds_rx`.
- Veto: `ivc` is a VW-bit interval counter. It saturates at 2^VW−1 and resets to 0 on an accepted photon.
  - `inveto = (ivc < cycles_to_veto)`.
  - When `inveto` is true, `phot = 0`. If `raw != 0` in that cycle, `collision` pulses for one cycle.
  - When `inveto` is false, `phot = raw`.
- Accepted photon (`phot != 0`):
  - If `ivc < NIPI`, IPI bin `ivc` is incremented.
  - `ivc` is loaded with 0.
- Counters: each channel counter adds `phot[i]`. IPI bins add 1. All increments saturate at 2^CW−1; they never wrap.
- Clear: `clr_req` passes through a 2-FF synchronizer. A rising edge of the synchronised level starts the sweep.
  - Channel counters zero in the first cycle of the sweep.
  - IPI bins zero one per cycle, over NIPI cycles.
  - `clr_busy` is high for the whole sweep. Increments during the sweep are discarded.
  - A new `clr_req` edge during a sweep restarts the sweep from bin 0.
- Passthrough: `out1 = |lvds_rx` registered and `out2 = |(lvds_rx & mask2)` registered. Veto, counters and histogram are frozen. `ivc` holds.
- Read: an address beyond NCH−1 or NIPI−1 returns 0.
  - A read of a bin being incremented in the same cycle returns the pre-increment value.

## Timing
- `lvds_rx` → `out1`/`out2`/`anyphot`/`collision`: 1 cycle (registered).
- `inveto` is registered from the next-state `ivc`. An accepted photon at cycle t gives `inveto` = 1 from t+1 through t+`cycles_to_veto`, provided `cycles_to_veto` > 0.
- `cycles_to_veto` = 0 means no veto; back-to-back photons are all accepted.
- IPI bin value = number of cycles between accepted photons minus 1. Consecutive-cycle photons land in bin 0.
- `rd_data`: 1-cycle latency from `rd_addr`/`rd_sel`.
- `clr_req` edge → `clr_busy` high: 3 cycles. The sweep lasts NIPI cycles.
- Reset values:
  - All outputs 0.
  - All counters and bins 0, `lvds_q` = 0.
  - `ivc` = 2^VW−1, so the block is not in veto after reset.
  - Reset mid-sweep aborts the sweep; everything is zeroed by reset anyway.

## Configuration
- `PHOT_IPI_HIST_EN`: when defined, the IPI histogram, its clear sweep and `rd_sel` = 1 are compiled in.
- When undefined:
  - No IPI storage is built.
  - `rd_sel` = 1 reads return 0.
  - `clr_busy` pulses high for 1 cycle per clear.
  - Veto, collision and channel counters are unchanged.

## Structure
- Package `phot_pkg`: `NCH_MAX`, `NIPI_MAX`, typedef `cnt_t` (CW-bit), the saturating-increment function, and the `rd_sel` encoding constants.
- Sub-module `ipi_hist`: NIPI×CW storage with increment port, clear-sweep FSM (IDLE/SWEEP), and read port. It is instantiated only under `PHOT_IPI_HIST_EN`.

## Test plan
- **Reset and idle:** `nrst` low, then high, with `cycles_to_veto` = 5 and `lvds_rx` = 0 → `inveto` = 0, all reads return 0.
- **Veto and collision:** `cycles_to_veto` = 3; pulse channel 0 at t0, channel 1 at t0+2, channel 2 at t0+4.
  - Required: `out` pulses for t0 and t0+4; `collision` pulses once.
  - Required: counters ch0 = 1, ch1 = 0, ch2 = 1; IPI bin 3 = 1.
- **Edge detection:** `edge_only` = 1 with channel 3 held high for 10 cycles, `cycles_to_veto` = 0 → ch3 counter = 1.
  - With `edge_only` = 0 → ch3 counter = 10, IPI bin 0 = 9.
- **Saturation:** CW = 4, 20 accepted photons on channel 0 → counter = 15.
  - An interval ≥ NIPI is not binned.
- **Clear sweep:** assert `clr_req` while photons arrive → `clr_busy` high 3 cycles later for NIPI cycles, then all bins read 0.
  - A second `clr_req` edge mid-sweep extends the sweep.
- **Passthrough:** `passthrough` = 1 with photon traffic → `out1` follows `|lvds_rx` with 1-cycle delay; counters are unchanged.
